// File: rtl/fb_draw_arbiter.sv
// Two-requester draw-command arbiter with front/back frame buffer swap on frame_sync.
// Define DRAW_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module fb_draw_arbiter #(
  parameter int unsigned FB_SIZE   = 614400,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [47:0] req_pixel,
  input  logic [47:0] req_len,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos,
  output logic [23:0] pixel,
  output logic [23:0] len,
  output logic        enable,
  input  logic        busy,
  input  logic        sys_vaild,
  input  logic        frame_sync,
  input  logic        swap_req,
  output logic [31:0] ping_addr,
  output logic [31:0] pong_addr,
  output logic        swap_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t      state;
  state_t      state_next;
  logic        last_granted;
  logic        swap_pending;
  logic        winner;
  logic        grant_now;
  logic        swap_now;
  logic [23:0] win_len;

  always_comb begin
`ifdef DRAW_FIXED_PRIO_EN
    winner = ~req[0];
`else
    // prefer whichever requester did not win last time
    winner = last_granted ? ~req[0] : req[1];
`endif
  end

  assign grant_now = (state == IDLE) && sys_vaild && !swap_pending && !swap_req && (req != 2'b00);
  assign swap_now  = (state == IDLE) && frame_sync && (swap_pending || swap_req);
  assign win_len   = winner ? req_len[47:24] : req_len[23:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    enable     = 1'b0;
    done       = 2'b00;
    case (state)
      IDLE: begin
        if (grant_now) state_next = (win_len == 24'd0) ? RELEASE : ISSUE;
      end
      ISSUE: begin
        enable = 1'b1;
        if (busy) state_next = WAIT;
      end
      WAIT: begin
        enable = 1'b1;
        if (!busy) state_next = RELEASE;
      end
      RELEASE: begin
        done       = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // command fields are captured once at grant and held until the grant is cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= 2'b00;
      last_granted <= 1'b1;
      x_pos        <= 16'd0;
      y_pos        <= 16'd0;
      pixel        <= 24'd0;
      len          <= 24'd0;
    end else if (grant_now) begin
      grant        <= winner ? 2'b10 : 2'b01;
      last_granted <= winner;
      x_pos        <= winner ? req_x[31:16] : req_x[15:0];
      y_pos        <= winner ? req_y[31:16] : req_y[15:0];
      pixel        <= winner ? req_pixel[47:24] : req_pixel[23:0];
      len          <= win_len;
    end else if (state == RELEASE) begin
      grant <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ping_addr    <= BASE_ADDR;
      pong_addr    <= BASE_ADDR + FB_SIZE;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= swap_now;
      if (swap_now) begin
        ping_addr    <= pong_addr;
        pong_addr    <= ping_addr;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_draw_arbiter.sv
// Directed self-checking bench for fb_draw_arbiter: draws, contention, len=0,
// buffer swaps (idle and mid-draw) and reset during a command.
module tb_fb_draw_arbiter;

  localparam int unsigned FB_SIZE = 614400;
`ifdef DRAW_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [47:0] req_pixel;
  logic [47:0] req_len;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic [23:0] pixel;
  logic [23:0] len;
  logic        enable;
  logic        busy;
  logic        sys_vaild;
  logic        frame_sync;
  logic        swap_req;
  logic [31:0] ping_addr;
  logic [31:0] pong_addr;
  logic        swap_done;

  int vectors     = 0;
  int miscompares = 0;

  fb_draw_arbiter #(.FB_SIZE(FB_SIZE), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_pixel(req_pixel), .req_len(req_len), .grant(grant), .done(done),
    .x_pos(x_pos), .y_pos(y_pos), .pixel(pixel), .len(len), .enable(enable),
    .busy(busy), .sys_vaild(sys_vaild), .frame_sync(frame_sync), .swap_req(swap_req),
    .ping_addr(ping_addr), .pong_addr(pong_addr), .swap_done(swap_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] r, input logic [15:0] x1, input logic [15:0] x0,
                                input logic [15:0] y1, input logic [15:0] y0,
                                input logic [23:0] l1, input logic [23:0] l0);
    req     = r;
    req_x   = {x1, x0};
    req_y   = {y1, y0};
    req_len = {l1, l0};
  endtask

  // runs grant -> ISSUE -> WAIT -> RELEASE, ending on the RELEASE cycle
  task automatic draw_cmd(input string tag, input logic [1:0] exp_grant,
                          input logic [15:0] exp_x, input logic [23:0] exp_len);
    tick();
    check_output({tag, " grant"}, 32'(grant), 32'(exp_grant));
    check_output({tag, " x_pos"}, 32'(x_pos), 32'(exp_x));
    check_output({tag, " len"}, 32'(len), 32'(exp_len));
    check_output({tag, " issue enable"}, 32'(enable), 32'd1);
    busy = 1'b1;
    tick();
    check_output({tag, " wait enable"}, 32'(enable), 32'd1);
    busy = 1'b0;
    tick();
    check_output({tag, " done"}, 32'(done), 32'(exp_grant));
    check_output({tag, " release enable"}, 32'(enable), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; busy = 1'b0; sys_vaild = 1'b0; frame_sync = 1'b0; swap_req = 1'b0;
    req_pixel = {24'h123456, 24'hABCDEF};
    apply_stimulus(2'b00, 16'd30, 16'd10, 16'd40, 16'd20, 24'd50, 24'd100);
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_output("rst grant", 32'(grant), 32'd0);
    check_output("rst done", 32'(done), 32'd0);
    check_output("rst enable", 32'(enable), 32'd0);
    check_output("rst swap_done", 32'(swap_done), 32'd0);
    check_output("rst x_pos", 32'(x_pos), 32'd0);
    check_output("rst len", 32'(len), 32'd0);
    check_output("rst ping", ping_addr, 32'd0);
    check_output("rst pong", pong_addr, FB_SIZE);
    rst_n = 1'b1;
    sys_vaild = 1'b1;

    $display("[TB] single draw");
    req = 2'b01;
    tick();
    check_output("single grant", 32'(grant), 32'd1);
    check_output("single enable", 32'(enable), 32'd1);
    check_output("single x_pos", 32'(x_pos), 32'd10);
    check_output("single y_pos", 32'(y_pos), 32'd20);
    check_output("single len", 32'(len), 32'd100);
    check_output("single pixel", 32'(pixel), 32'hABCDEF);
    busy = 1'b1;
    tick();
    req = 2'b00;
    req_x = 32'h0000_03E7;
    sys_vaild = 1'b0;
    repeat (99) tick();
    check_output("single hold enable", 32'(enable), 32'd1);
    check_output("single hold x_pos", 32'(x_pos), 32'd10);
    check_output("single hold done", 32'(done), 32'd0);
    busy = 1'b0;
    tick();
    check_output("single done", 32'(done), 32'd1);
    check_output("single release enable", 32'(enable), 32'd0);
    check_output("single release grant", 32'(grant), 32'd1);
    tick();
    check_output("single idle done", 32'(done), 32'd0);
    check_output("single idle grant", 32'(grant), 32'd0);
    req_x = {16'd30, 16'd10};
    req = 2'b01;
    tick();
    check_output("no sys_vaild grant", 32'(grant), 32'd0);
    req = 2'b00;
    sys_vaild = 1'b1;

    $display("[TB] contention");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] eg;
      eg = (FIXED_PRIO || (i % 2 == 0)) ? 2'b01 : 2'b10;
      draw_cmd("contend", eg, (eg == 2'b01) ? 16'd10 : 16'd30, (eg == 2'b01) ? 24'd100 : 24'd50);
      if (i == 3) req = 2'b00;
      tick();
      check_output("contend gap grant", 32'(grant), 32'd0);
      check_output("contend gap enable", 32'(enable), 32'd0);
    end

    $display("[TB] zero length");
    req_len = {24'd50, 24'd0};
    req = 2'b01;
    tick();
    check_output("len0 done", 32'(done), 32'd1);
    check_output("len0 enable", 32'(enable), 32'd0);
    check_output("len0 grant", 32'(grant), 32'd1);
    req = 2'b00;
    tick();
    check_output("len0 idle done", 32'(done), 32'd0);
    check_output("len0 idle grant", 32'(grant), 32'd0);
    req_len = {24'd50, 24'd100};

    $display("[TB] idle swap");
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check_output("swap pending ping", ping_addr, 32'd0);
    check_output("swap pending done", 32'(swap_done), 32'd0);
    req = 2'b01;
    repeat (4) begin
      tick();
      check_output("swap blocks grant", 32'(grant), 32'd0);
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check_output("swap ping", ping_addr, FB_SIZE);
    check_output("swap pong", pong_addr, 32'd0);
    check_output("swap done pulse", 32'(swap_done), 32'd1);
    check_output("swap cycle grant", 32'(grant), 32'd0);
    tick();
    check_output("swap done end", 32'(swap_done), 32'd0);
    check_output("post swap grant", 32'(grant), 32'd1);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check_output("post swap done", 32'(done), 32'd1);
    req = 2'b00;
    tick();

    $display("[TB] reset during wait");
    req = 2'b01;
    tick();
    check_output("rstw grant", 32'(grant), 32'd1);
    busy = 1'b1;
    tick();
    check_output("rstw enable", 32'(enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rstw async enable", 32'(enable), 32'd0);
    check_output("rstw async grant", 32'(grant), 32'd0);
    check_output("rstw async done", 32'(done), 32'd0);
    check_output("rstw async ping", ping_addr, 32'd0);
    check_output("rstw async pong", pong_addr, FB_SIZE);
    req = 2'b00;
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_output("rstw after done", 32'(done), 32'd0);
    check_output("rstw after grant", 32'(grant), 32'd0);

    $display("[TB] swap during draw");
    req = 2'b01;
    tick();
    check_output("sdraw grant", 32'(grant), 32'd1);
    busy = 1'b1;
    tick();
    swap_req = 1'b1;
    frame_sync = 1'b1;
    req = 2'b11;
    tick();
    swap_req = 1'b0;
    frame_sync = 1'b0;
    check_output("sdraw no swap ping", ping_addr, 32'd0);
    check_output("sdraw no swap_done", 32'(swap_done), 32'd0);
    check_output("sdraw enable", 32'(enable), 32'd1);
    busy = 1'b0;
    tick();
    check_output("sdraw done", 32'(done), 32'd1);
    req = 2'b10;
    repeat (3) begin
      tick();
      check_output("sdraw blocked grant", 32'(grant), 32'd0);
    end
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check_output("sdraw swap ping", ping_addr, FB_SIZE);
    check_output("sdraw swap pong", pong_addr, 32'd0);
    check_output("sdraw swap_done", 32'(swap_done), 32'd1);
    check_output("sdraw swap grant", 32'(grant), 32'd0);
    tick();
    check_output("sdraw req1 grant", 32'(grant), 32'd2);
    check_output("sdraw req1 x_pos", 32'(x_pos), 32'd30);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check_output("sdraw req1 done", 32'(done), 32'd2);
    req = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
